ula_mixer: RTL and testbench

ULA_MIXER -- requirements
Module: ula_mixer

---
 rtl/ula_mixer_pkg.sv | 27 ++
 rtl/ula_mixer_sd.sv | 24 ++
 rtl/ula_mixer.sv | 178 +++++++++++++++++
 tb/tb_ula_mixer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_mixer_pkg.sv
// Shared types and width helpers for the ULA audio mixer.
package ula_mixer_pkg;

    // Mixer sequencing states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StSat  = 2'd2
    } state_e;

    // Width of one sample*gain product
    function automatic int unsigned prod_w(input int unsigned iw, input int unsigned vw);
        return iw + vw;
    endfunction

    // Accumulator width: product plus headroom for summing nch products
    function automatic int unsigned acc_w(input int unsigned iw, input int unsigned vw,
                                          input int unsigned nch);
        return iw + vw + $clog2(nch);
    endfunction

    // Channel index width
    function automatic int unsigned idx_w(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/ula_mixer_sd.sv
// First-order sigma-delta DAC: the carry out of a wrapping accumulator is the bitstream.
module ula_mixer_sd #(
    parameter int unsigned OW = 9
) (
    input  logic          clk_sys,
    input  logic          nRESET,
    input  logic [OW-1:0] din,
    output logic          dout
);

    logic [OW:0] acc_q;

    // Add the input to the low bits each cycle; the previous carry is dropped
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            acc_q <= '0;
        end else begin
            acc_q <= {1'b0, acc_q[OW-1:0]} + {1'b0, din};
        end
    end

    assign dout = acc_q[OW];

endmodule

// File: rtl/ula_mixer.sv
// Multi-channel stereo mixer: serial multiply-accumulate over channels, saturation,
// sticky status flags and two sigma-delta DAC outputs.
module ula_mixer
    import ula_mixer_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned IW  = 8,
    parameter int unsigned VW  = 4,
    parameter int unsigned OW  = 9
) (
    input  logic              clk_sys,
    input  logic              nRESET,
    input  logic              ce,
    input  logic [NCH*IW-1:0] ch_in,
    input  logic [NCH*VW-1:0] vol_l,
    input  logic [NCH*VW-1:0] vol_r,
    input  logic              mute,
    input  logic              flag_clr,
    output logic [OW-1:0]     mix_l,
    output logic [OW-1:0]     mix_r,
    output logic              mix_valid,
    output logic              clip_l,
    output logic              clip_r,
    output logic              overrun,
    output logic              AUDIO_L,
    output logic              AUDIO_R
);

    localparam int unsigned PW = prod_w(IW, VW);
    localparam int unsigned AW = acc_w(IW, VW, NCH);
    localparam int unsigned XW = idx_w(NCH);
    localparam int unsigned RW = AW - VW;
    localparam logic [31:0] MIX_MAX = (32'd1 << OW) - 32'd1;

    state_e              state_q, state_d;
    logic [XW-1:0]       idx_q, idx_d;
    logic [AW-1:0]       acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [NCH*IW-1:0]   ch_q, ch_d;
    logic [NCH*VW-1:0]   vl_q, vl_d, vr_q, vr_d;
    logic                mute_q, mute_d;
    logic [OW-1:0]       mix_l_q, mix_l_d, mix_r_q, mix_r_d;
    logic                mix_valid_q, mix_valid_d;
    logic                clip_l_q, clip_l_d, clip_r_q, clip_r_d, overrun_q, overrun_d;

    logic [IW-1:0]       smp;
    logic [VW-1:0]       gain_l, gain_r;
    logic [PW-1:0]       prod_l, prod_r;
    logic [RW-1:0]       r_l, r_r;
    logic                over_l, over_r;
    logic [OW-1:0]       sat_l, sat_r;
    logic                clip_l_set, clip_r_set;

    // Current channel operands come from the snapshot, never the live inputs
    assign smp    = ch_q[int'(idx_q)*IW +: IW];
    assign gain_l = vl_q[int'(idx_q)*VW +: VW];
    assign gain_r = vr_q[int'(idx_q)*VW +: VW];
    assign prod_l = PW'(smp) * PW'(gain_l);
    assign prod_r = PW'(smp) * PW'(gain_r);

    // Drop the gain fraction bits, then clamp to the output range
    assign r_l    = acc_l_q[AW-1:VW];
    assign r_r    = acc_r_q[AW-1:VW];
    assign over_l = 32'(r_l) > MIX_MAX;
    assign over_r = 32'(r_r) > MIX_MAX;
    assign sat_l  = over_l ? {OW{1'b1}} : OW'(r_l);
    assign sat_r  = over_r ? {OW{1'b1}} : OW'(r_r);

    // Next-state, datapath and flag logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        ch_d        = ch_q;
        vl_d        = vl_q;
        vr_d        = vr_q;
        mute_d      = mute_q;
        mix_l_d     = mix_l_q;
        mix_r_d     = mix_r_q;
        mix_valid_d = 1'b0;
        clip_l_set  = 1'b0;
        clip_r_set  = 1'b0;

        case (state_q)
            StIdle: begin
                if (ce) begin
                    ch_d    = ch_in;
                    vl_d    = vol_l;
                    vr_d    = vol_r;
                    mute_d  = mute;
                    acc_l_d = '0;
                    acc_r_d = '0;
                    idx_d   = '0;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                acc_l_d = acc_l_q + AW'(prod_l);
                acc_r_d = acc_r_q + AW'(prod_r);
                idx_d   = idx_q + XW'(1);
                if (idx_q == XW'(NCH - 1)) begin
                    state_d = StSat;
                end
            end
            StSat: begin
                mix_l_d     = mute_q ? '0 : sat_l;
                mix_r_d     = mute_q ? '0 : sat_r;
                mix_valid_d = 1'b1;
                clip_l_set  = over_l;
                clip_r_set  = over_r;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Clear first so a coincident set event wins
        clip_l_d  = (clip_l_q & ~flag_clr) | clip_l_set;
        clip_r_d  = (clip_r_q & ~flag_clr) | clip_r_set;
        overrun_d = (overrun_q & ~flag_clr) | (ce & (state_q != StIdle));
    end

    // State and datapath registers
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            ch_q        <= '0;
            vl_q        <= '0;
            vr_q        <= '0;
            mute_q      <= 1'b0;
            mix_l_q     <= '0;
            mix_r_q     <= '0;
            mix_valid_q <= 1'b0;
            clip_l_q    <= 1'b0;
            clip_r_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            ch_q        <= ch_d;
            vl_q        <= vl_d;
            vr_q        <= vr_d;
            mute_q      <= mute_d;
            mix_l_q     <= mix_l_d;
            mix_r_q     <= mix_r_d;
            mix_valid_q <= mix_valid_d;
            clip_l_q    <= clip_l_d;
            clip_r_q    <= clip_r_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mix_l     = mix_l_q;
    assign mix_r     = mix_r_q;
    assign mix_valid = mix_valid_q;
    assign clip_l    = clip_l_q;
    assign clip_r    = clip_r_q;
    assign overrun   = overrun_q;

    ula_mixer_sd #(.OW(OW)) u_dac_l (
        .clk_sys (clk_sys),
        .nRESET  (nRESET),
        .din     (mix_l_q),
        .dout    (AUDIO_L)
    );

    ula_mixer_sd #(.OW(OW)) u_dac_r (
        .clk_sys (clk_sys),
        .nRESET  (nRESET),
        .din     (mix_r_q),
        .dout    (AUDIO_R)
    );

endmodule

// File: tb/tb_ula_mixer.sv
// Self-checking bench for ula_mixer: directed cases plus randomized mixes against an
// arithmetic reference model.
module tb_ula_mixer;

    localparam int unsigned NCH  = 4;
    localparam int unsigned IW   = 8;
    localparam int unsigned VW   = 4;
    localparam int unsigned OW   = 9;
    localparam int unsigned MAXV = (1 << OW) - 1;
    localparam int unsigned WIN  = 1 << OW;

    logic              clk_sys  = 1'b0;
    logic              nRESET   = 1'b0;
    logic              ce       = 1'b0;
    logic              mute     = 1'b0;
    logic              flag_clr = 1'b0;
    logic [NCH*IW-1:0] ch_in    = '0;
    logic [NCH*VW-1:0] vol_l    = '0;
    logic [NCH*VW-1:0] vol_r    = '0;
    logic [OW-1:0]     mix_l, mix_r;
    logic              mix_valid, clip_l, clip_r, overrun, AUDIO_L, AUDIO_R;

    int unsigned m_ch[NCH];
    int unsigned m_vl[NCH];
    int unsigned m_vr[NCH];
    bit          m_mute;

    int n_checks = 0;
    int n_fail   = 0;

    ula_mixer #(.NCH(NCH), .IW(IW), .VW(VW), .OW(OW)) dut (
        .clk_sys   (clk_sys),
        .nRESET    (nRESET),
        .ce        (ce),
        .ch_in     (ch_in),
        .vol_l     (vol_l),
        .vol_r     (vol_r),
        .mute      (mute),
        .flag_clr  (flag_clr),
        .mix_l     (mix_l),
        .mix_r     (mix_r),
        .mix_valid (mix_valid),
        .clip_l    (clip_l),
        .clip_r    (clip_r),
        .overrun   (overrun),
        .AUDIO_L   (AUDIO_L),
        .AUDIO_R   (AUDIO_R)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_all(input int unsigned c, input int unsigned gl, input int unsigned gr);
        for (int k = 0; k < NCH; k++) begin
            m_ch[k] = c;
            m_vl[k] = gl;
            m_vr[k] = gr;
        end
        m_mute = 1'b0;
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NCH; k++) begin
            ch_in[k*IW +: IW] = IW'(m_ch[k]);
            vol_l[k*VW +: VW] = VW'(m_vl[k]);
            vol_r[k*VW +: VW] = VW'(m_vr[k]);
        end
        mute = m_mute;
    endtask

    // Reference: weighted sum, drop gain fraction, clamp; mute zeroes output only
    task automatic model(output int unsigned el, output int unsigned er,
                         output bit cl, output bit cr);
        int unsigned sl, sr, rl, rr;
        sl = 0;
        sr = 0;
        for (int k = 0; k < NCH; k++) begin
            sl += m_ch[k] * m_vl[k];
            sr += m_ch[k] * m_vr[k];
        end
        rl = sl / (1 << VW);
        rr = sr / (1 << VW);
        cl = rl > MAXV;
        cr = rr > MAXV;
        el = m_mute ? 0 : (cl ? MAXV : rl);
        er = m_mute ? 0 : (cr ? MAXV : rr);
    endtask

    task automatic clear_flags();
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
    endtask

    // Pulse ce; optionally retrigger 2 cycles later (with different inputs) and flag_clr.
    // lat is the number of edges from the ce sample edge's predecessor to mix_valid.
    task automatic run_mix(input bit dbl, input bit clr_with, output int lat);
        ce  = 1'b1;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            ce       = 1'b0;
            flag_clr = 1'b0;
            if (dbl && c == 2) begin
                ce       = 1'b1;
                ch_in    = ~ch_in;
                flag_clr = clr_with;
            end
            if (mix_valid) begin
                lat = c;
                break;
            end
        end
        ce       = 1'b0;
        flag_clr = 1'b0;
    endtask

    task automatic check_mix(input string tag);
        int          lat;
        int unsigned el, er;
        bit          cl, cr;
        clear_flags();
        drive_inputs();
        model(el, er, cl, cr);
        run_mix(1'b0, 1'b0, lat);
        check_val({tag, " latency"}, lat, NCH + 2);
        check_val({tag, " mix_l"}, mix_l, el);
        check_val({tag, " mix_r"}, mix_r, er);
        check_val({tag, " clip_l"}, clip_l, cl);
        check_val({tag, " clip_r"}, clip_r, cr);
        step();
        check_val({tag, " valid width"}, mix_valid, 0);
    endtask

    task automatic count_ones(output int unsigned nl, output int unsigned nr);
        repeat (3) step();
        nl = 0;
        nr = 0;
        repeat (WIN) begin
            step();
            nl += AUDIO_L;
            nr += AUDIO_R;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " mix_l"}, mix_l, 0);
        check_val({tag, " mix_r"}, mix_r, 0);
        check_val({tag, " mix_valid"}, mix_valid, 0);
        check_val({tag, " clip_l"}, clip_l, 0);
        check_val({tag, " clip_r"}, clip_r, 0);
        check_val({tag, " overrun"}, overrun, 0);
        check_val({tag, " AUDIO_L"}, AUDIO_L, 0);
        check_val({tag, " AUDIO_R"}, AUDIO_R, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, nv;
        int unsigned nl, nr, el, er;
        bit          cl, cr;

        repeat (3) step();
        check_reset_outputs("reset");
        nRESET = 1'b1;
        step();

        // Single channel, left gain only
        set_all(0, 0, 0);
        m_ch[0] = 255;
        m_vl[0] = 15;
        check_mix("single");
        check_val("single mix_l const", mix_l, 239);

        // Full scale on every channel saturates both sides
        set_all(255, 15, 15);
        check_mix("full");
        check_val("full mix_l const", mix_l, 511);
        check_val("full clip_l const", clip_l, 1);
        clear_flags();
        check_val("full clip_l cleared", clip_l, 0);
        check_val("full clip_r cleared", clip_r, 0);

        // Muted full scale still flags the clip
        set_all(255, 15, 15);
        m_mute = 1'b1;
        check_mix("mute");

        // Retrigger during ACC is ignored but flagged
        set_all(0, 0, 0);
        m_ch[0] = 255;
        m_vl[0] = 15;
        clear_flags();
        check_val("ovr pre", overrun, 0);
        drive_inputs();
        run_mix(1'b1, 1'b0, lat);
        check_val("ovr latency", lat, NCH + 2);
        check_val("ovr mix_l", mix_l, 239);
        check_val("ovr mix_r", mix_r, 0);
        check_val("ovr flag", overrun, 1);
        nv = 0;
        repeat (12) begin
            step();
            nv += int'(mix_valid);
        end
        check_val("ovr extra valid", nv, 0);
        clear_flags();
        check_val("ovr cleared", overrun, 0);
        drive_inputs();
        run_mix(1'b1, 1'b1, lat);
        check_val("ovr set wins", overrun, 1);

        // DAC density for constant inputs
        set_all(0, 0, 0);
        m_ch[0] = 255; m_vl[0] = 15; m_vr[0] = 15;
        m_ch[1] = 136; m_vl[1] = 2;  m_vr[1] = 2;
        check_mix("dac256");
        count_ones(nl, nr);
        check_val("dac256 ones_l", nl, 256);
        check_val("dac256 ones_r", nr, 256);
        set_all(255, 15, 15);
        check_mix("dac511");
        count_ones(nl, nr);
        check_val("dac511 ones_l", nl, 511);
        check_val("dac511 ones_r", nr, 511);
        set_all(200, 0, 0);
        check_mix("dac0");
        count_ones(nl, nr);
        check_val("dac0 ones_l", nl, 0);
        check_val("dac0 ones_r", nr, 0);

        // Reset in the second ACC cycle aborts the mix
        set_all(0, 0, 0);
        m_ch[0] = 255;
        m_vl[0] = 15;
        check_mix("prerst");
        ce = 1'b1;
        step();
        ce = 1'b0;
        step();
        nRESET = 1'b0;
        #1;
        check_reset_outputs("async rst");
        nv = 0;
        repeat (4) begin
            step();
            nv += int'(mix_valid);
        end
        check_val("rst no valid", nv, 0);
        nRESET = 1'b1;
        nv = 0;
        repeat (10) begin
            step();
            nv += int'(mix_valid);
        end
        check_val("rst idle no valid", nv, 0);
        check_mix("postrst");

        // Randomized mixes against the reference model
        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < NCH; k++) begin
                m_ch[k] = (it % 3 == 0) ? $urandom_range(200, 255) : $urandom_range(0, 255);
                m_vl[k] = $urandom_range(0, 15);
                m_vr[k] = $urandom_range(0, 15);
            end
            m_mute = ($urandom_range(0, 3) == 0);
            model(el, er, cl, cr);
            check_mix($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
